div_16bit_iterative: RTL and testbench

Unsigned 16-bit restoring divider for the WISC datapath. It computes one quotient bit per cycle using a 17-bit trial subtraction. It accepts operands on a single-cycle start strobe and returns quotient and remainder with a one-cycle done pulse. It sits beside the ALU's lookahead adder tree as the multi-cycle arithmetic unit, and the pipeline stalls on busy.

---
 rtl/div_16bit_iterative.sv | 114 +++++++++++
 tb/tb_div_16bit_iterative.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_16bit_iterative.sv
// Unsigned 16-bit restoring divider: one quotient bit per cycle via a 17-bit trial subtraction.
// Operands are taken on a start strobe; quotient/remainder are returned with a one-cycle done pulse.
module div_16bit_iterative (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] q_q, q_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] dvsr_q, dvsr_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] remo_q, remo_d;
  logic        dbz_q, dbz_d;

  logic [16:0] rem_sh;
  logic [16:0] trial;
  logic        accept;

  // rem_sh keeps the bit shifted out of rem so divisors >= 16'h8000 compare correctly.
  always_comb begin
    rem_sh = {rem_q, q_q[15]};
    trial  = rem_sh + {1'b1, ~dvsr_q} + 17'd1;
    accept = start && (state_q != RUN);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (divisor != 16'd0) begin
            q_d     = dividend;
            dvsr_d  = divisor;
            rem_d   = 16'd0;
            cnt_d   = 5'd0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            quot_d  = 16'hFFFF;
            remo_d  = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (!trial[16]) begin
          rem_d = trial[15:0];
          q_d   = {q_q[14:0], 1'b1};
        end else begin
          rem_d = rem_sh[15:0];
          q_d   = {q_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          quot_d  = q_d;
          remo_d  = rem_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      quot_q  <= 16'd0;
      remo_q  <= 16'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working registers are only meaningful during RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    q_q    <= q_d;
    rem_q  <= rem_d;
    dvsr_q <= dvsr_d;
  end

  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_div_16bit_iterative.sv
// Directed bench for div_16bit_iterative: latency, edge operands, divide-by-zero,
// ignored start, back-to-back, async reset abort and a short random sweep.
module tb_div_16bit_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = 16'd0;
  logic [15:0] divisor = 16'd0;
  logic [15:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;

  div_16bit_iterative dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle; returns at the negedge of the first cycle after acceptance.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Count cycles (first post-start cycle = 1) until done, also counting busy cycles.
  task automatic wait_done(output int n, output int nbusy);
    n = 1;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if (quotient !== 16'd0 || remainder !== 16'd0 || busy !== 1'b0 || done !== 1'b0 ||
        div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: q=%h r=%h busy=%b done=%b dbz=%b, required all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int n, nb;
    do_start(16'd100, 16'd7);
    wait_done(n, nb);
    tests++;
    if (n !== 17) begin
      fails++;
      $display("FAIL basic_latency: done at cycle %0d, required 17", n);
    end
    tests++;
    if (nb !== 16) begin
      fails++;
      $display("FAIL basic_busy: busy for %0d cycles, required 16", nb);
    end
    tests++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required q=14 r=2 dbz=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_edges;
    logic [15:0] va [4] = '{16'hFFFF, 16'hFFFF, 16'd3,  16'h8000};
    logic [15:0] vb [4] = '{16'h0001, 16'hFFFF, 16'd10, 16'h8001};
    logic [15:0] vq [4] = '{16'hFFFF, 16'h0001, 16'd0,  16'h0000};
    logic [15:0] vr [4] = '{16'h0000, 16'h0000, 16'd3,  16'h8000};
    int n, nb;
    for (int i = 0; i < 4; i++) begin
      do_start(va[i], vb[i]);
      wait_done(n, nb);
      tests++;
      if (n !== 17 || quotient !== vq[i] || remainder !== vr[i] ||
          (32'(quotient) * 32'(vb[i]) + 32'(remainder)) !== 32'(va[i])) begin
        fails++;
        $display("FAIL edge_%0d: %h/%h gave q=%h r=%h at cycle %0d, required q=%h r=%h at 17",
                 i, va[i], vb[i], quotient, remainder, n, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int n, nb;
    do_start(16'd5, 16'd0);
    wait_done(n, nb);
    tests++;
    if (n !== 1 || nb !== 0) begin
      fails++;
      $display("FAIL dbz_timing: done at cycle %0d busy cycles %0d, required 1 and 0", n, nb);
    end
    tests++;
    if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required q=ffff r=5 dbz=1",
               quotient, remainder, div_by_zero);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (div_by_zero !== 1'b1 || quotient !== 16'hFFFF) begin
      fails++;
      $display("FAIL dbz_hold: dbz=%b q=%h in idle, required 1 and ffff", div_by_zero, quotient);
    end
    do_start(16'd9, 16'd3);
    wait_done(n, nb);
    tests++;
    if (quotient !== 16'd3 || remainder !== 16'd0 || div_by_zero !== 1'b0 || n !== 17) begin
      fails++;
      $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b cycle %0d, required q=3 r=0 dbz=0 at 17",
               quotient, remainder, div_by_zero, n);
    end
  endtask

  task automatic test_start_ignored;
    int n, nb;
    do_start(16'd1000, 16'd3);
    repeat (4) @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(n, nb);
    n = n + 5;
    tests++;
    if (n !== 17 || quotient !== 16'd333 || remainder !== 16'd1) begin
      fails++;
      $display("FAIL start_ignored: q=%0d r=%0d at cycle %0d, required q=333 r=1 at 17",
               quotient, remainder, n);
    end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    do_start(16'd100, 16'd7);
    wait_done(n, nb);
    dividend = 16'd200;
    divisor  = 16'd9;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b done=%b after start in done cycle, required 1 0",
               busy, done);
    end
    wait_done(n, nb);
    tests++;
    if (n !== 17 || quotient !== 16'd22 || remainder !== 16'd2) begin
      fails++;
      $display("FAIL b2b_result: q=%0d r=%0d at cycle %0d, required q=22 r=2 at 17",
               quotient, remainder, n);
    end
  endtask

  task automatic test_async_reset;
    int n, nb;
    bit seen;
    do_start(16'd1000, 16'd7);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (quotient !== 16'd0 || remainder !== 16'd0 || busy !== 1'b0 || done !== 1'b0 ||
        div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: q=%h r=%h busy=%b done=%b dbz=%b, required all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: busy/done activity seen after reset, required none");
    end
    do_start(16'd42, 16'd6);
    wait_done(n, nb);
    tests++;
    if (n !== 17 || quotient !== 16'd7 || remainder !== 16'd0) begin
      fails++;
      $display("FAIL post_reset_op: q=%0d r=%0d at cycle %0d, required q=7 r=0 at 17",
               quotient, remainder, n);
    end
  endtask

  task automatic test_random;
    int n, nb;
    int bad = 0;
    logic [15:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 4 == 0) b = 16'($urandom_range(1, 255));
      if (b == 16'd0) b = 16'd1;
      do_start(a, b);
      wait_done(n, nb);
      tests++;
      if (n !== 17 || quotient !== a / b || remainder !== a % b ||
          remainder >= b) begin
        fails++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_%0d: %0d/%0d gave q=%0d r=%0d, required q=%0d r=%0d",
                   i, a, b, quotient, remainder, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edges;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
